// File: rtl/qmult.sv
// Signed Q-format fixed-point multiplier with saturation and overflow flag.
// PIPE selects a combinational result or a single registered output stage.
module qmult #(
    parameter int Q    = 18,
    parameter int N    = 32,
    parameter int PIPE = 0
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] result,
    output logic         overflow,
    input  logic         clk,
    input  logic         reset
);

    localparam logic [N-1:0] MAX_POS = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] MAX_NEG = {1'b1, {(N-1){1'b0}}};

    logic signed [2*N-1:0] a_ext_s;
    logic signed [2*N-1:0] b_ext_s;
    logic signed [2*N-1:0] product_s;
    logic [N-Q:0]          hi_s;
    logic [N-1:0]          sat_result_s;
    logic                  sat_overflow_s;
    logic                  unused_ok_s;

    // Exact 2N-bit signed product from sign-extended operands
    assign a_ext_s   = {{N{a[N-1]}}, a};
    assign b_ext_s   = {{N{b[N-1]}}, b};
    assign product_s = a_ext_s * b_ext_s;

    // Bits that must all match the sign of the scaled result for it to be in range
    assign hi_s = product_s[2*N-1:N-1+Q];

    // Truncating fractional bits below the LSB is a plain floor, so they are dropped
    assign unused_ok_s = &{1'b0, product_s[Q-1:0], clk, reset};

    // Range check and saturation toward the product's sign
    always_comb begin
        sat_result_s   = product_s[N-1+Q:Q];
        sat_overflow_s = 1'b0;
        if (!((&hi_s) || !(|hi_s))) begin
            sat_overflow_s = 1'b1;
            if (product_s[2*N-1]) begin
                sat_result_s = MAX_NEG;
            end else begin
                sat_result_s = MAX_POS;
            end
        end else begin
            sat_result_s   = product_s[N-1+Q:Q];
            sat_overflow_s = 1'b0;
        end
    end

    generate
        if (PIPE != 0) begin : g_pipe
            logic [N-1:0] result_r;
            logic         overflow_r;

            // Output stage; reset clears it immediately and discards any in-flight product
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    result_r   <= {N{1'b0}};
                    overflow_r <= 1'b0;
                end else begin
                    result_r   <= sat_result_s;
                    overflow_r <= sat_overflow_s;
                end
            end

            assign result   = result_r;
            assign overflow = overflow_r;
        end else begin : g_comb
            assign result   = sat_result_s;
            assign overflow = sat_overflow_s;
        end
    endgenerate

endmodule

// File: tb/tb_qmult.sv
// Directed-vector bench for qmult (N=32, Q=18), covering the combinational
// and the registered variants side by side on shared operands.
module tb_qmult;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_r;
        logic        exp_o;
    } vec_t;

    logic        clk;
    logic        reset;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res_c;
    logic        ovf_c;
    logic [31:0] res_p;
    logic        ovf_p;

    int n_vec;
    int n_bad;

    vec_t vecs[16];

    qmult #(.Q(18), .N(32), .PIPE(0)) u_comb (
        .a(a), .b(b), .result(res_c), .overflow(ovf_c), .clk(clk), .reset(reset)
    );

    qmult #(.Q(18), .N(32), .PIPE(1)) u_pipe (
        .a(a), .b(b), .result(res_p), .overflow(ovf_p), .clk(clk), .reset(reset)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got_r, input logic got_o,
                         input logic [31:0] exp_r, input logic exp_o);
        n_vec++;
        if (got_r !== exp_r || got_o !== exp_o) begin
            n_bad++;
            $display("FAIL %s: got result=%h overflow=%b, expected result=%h overflow=%b",
                     name, got_r, got_o, exp_r, exp_o);
        end
    endtask

    // Reference: floor(a*b / 2^18) computed in 64-bit integers, then clamped
    function automatic void model(input logic [31:0] ma, input logic [31:0] mb,
                                  output logic [31:0] r, output logic o);
        longint p;
        longint s;
        p = longint'($signed(ma)) * longint'($signed(mb));
        s = p >>> 18;
        if (s > 64'sd2147483647) begin
            r = 32'h7FFF_FFFF;
            o = 1'b1;
        end else if (s < -64'sd2147483648) begin
            r = 32'h8000_0000;
            o = 1'b1;
        end else begin
            r = s[31:0];
            o = 1'b0;
        end
    endfunction

    initial begin
        logic [31:0] mr;
        logic        mo;
        logic [31:0] prev_r;
        logic        prev_o;

        vecs[0]  = '{32'h0006_0000, 32'h0008_0000, 32'h000C_0000, 1'b0};
        vecs[1]  = '{32'hFFFA_0000, 32'h0008_0000, 32'hFFF4_0000, 1'b0};
        vecs[2]  = '{32'hFFFA_0000, 32'hFFF8_0000, 32'h000C_0000, 1'b0};
        vecs[3]  = '{32'h0006_0000, 32'hFFF8_0000, 32'hFFF4_0000, 1'b0};
        vecs[4]  = '{32'h4000_0000, 32'h0010_0000, 32'h7FFF_FFFF, 1'b1};
        vecs[5]  = '{32'h4000_0000, 32'hFFF0_0000, 32'h8000_0000, 1'b1};
        vecs[6]  = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 1'b0};
        vecs[7]  = '{32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0};
        vecs[8]  = '{32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1};
        vecs[9]  = '{32'h0000_0000, 32'h8000_0000, 32'h0000_0000, 1'b0};
        vecs[10] = '{32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[11] = '{32'h8000_0000, 32'h0004_0000, 32'h8000_0000, 1'b0};
        vecs[12] = '{32'h7FFF_FFFF, 32'h0004_0000, 32'h7FFF_FFFF, 1'b0};
        vecs[13] = '{32'h8000_0000, 32'hFFFC_0000, 32'h7FFF_FFFF, 1'b1};
        vecs[14] = '{32'h0002_0000, 32'h0002_0000, 32'h0001_0000, 1'b0};
        vecs[15] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};

        n_vec = 0;
        n_bad = 0;
        clk   = 1'b0;
        reset = 1'b0;
        a     = 32'h4000_0000;
        b     = 32'h0010_0000;

        #2;
        check("reset_state", res_p, ovf_p, 32'h0000_0000, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        // Directed table: combinational check mid-cycle, registered one after the edge
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            a = vecs[i].a;
            b = vecs[i].b;
            #1;
            check($sformatf("comb_vec%0d", i), res_c, ovf_c, vecs[i].exp_r, vecs[i].exp_o);
            @(posedge clk);
            #1;
            check($sformatf("pipe_vec%0d", i), res_p, ovf_p, vecs[i].exp_r, vecs[i].exp_o);
        end

        // Random operands with random magnitudes against the integer model
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            a = $urandom >> $urandom_range(0, 20);
            b = $urandom >> $urandom_range(0, 20);
            if ($urandom_range(0, 1) == 1) a = -a;
            if ($urandom_range(0, 1) == 1) b = -b;
            model(a, b, mr, mo);
            #1;
            check("comb_rand", res_c, ovf_c, mr, mo);
            @(posedge clk);
            #1;
            check("pipe_rand", res_p, ovf_p, mr, mo);
        end

        // Back-to-back stream: each output appears exactly one edge after its operands
        @(negedge clk);
        a = vecs[0].a;
        b = vecs[0].b;
        @(posedge clk);
        #1;
        check("stream0", res_p, ovf_p, vecs[0].exp_r, vecs[0].exp_o);
        a = vecs[1].a;
        b = vecs[1].b;
        @(posedge clk);
        #1;
        check("stream1", res_p, ovf_p, vecs[1].exp_r, vecs[1].exp_o);
        a = vecs[4].a;
        b = vecs[4].b;
        @(posedge clk);
        #1;
        check("stream2", res_p, ovf_p, vecs[4].exp_r, vecs[4].exp_o);

        // Mid-stream reset clears outputs without a clock edge and drops the pending pair
        a = vecs[5].a;
        b = vecs[5].b;
        #2;
        reset = 1'b0;
        #1;
        check("async_reset", res_p, ovf_p, 32'h0000_0000, 1'b0);
        @(posedge clk);
        #1;
        check("reset_held", res_p, ovf_p, 32'h0000_0000, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        #2;
        check("post_release", res_p, ovf_p, 32'h0000_0000, 1'b0);
        a = vecs[2].a;
        b = vecs[2].b;
        @(posedge clk);
        #1;
        check("first_after_reset", res_p, ovf_p, vecs[2].exp_r, vecs[2].exp_o);

        // Overflow is not sticky
        prev_r = vecs[14].exp_r;
        prev_o = vecs[14].exp_o;
        a = vecs[8].a;
        b = vecs[8].b;
        @(posedge clk);
        #1;
        a = vecs[14].a;
        b = vecs[14].b;
        @(posedge clk);
        #1;
        check("overflow_clears", res_p, ovf_p, prev_r, prev_o);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
